// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: mode encoding for add/subtract and the
// ceiling-division helper used to size pipelined datapaths.
package arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// N-bit ripple-carry slice built from full-adder cells. Besides the sum and
// carry-out it exposes the carry into its MSB so the owner can form signed
// overflow without re-deriving it.
module adder_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         cm
);

    logic [N:0] carry;

    // Ripple chain: each cell produces its sum bit and the carry for the next.
    always_comb begin
        s        = '0;
        carry    = '0;
        carry[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        co = carry[N];
        cm = carry[N-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. The WIDTH-bit operation is cut into CHUNK-bit
// slices; stage k resolves slice k and registers its carry for stage k+1.
// Operands not yet consumed and result bits already produced ride along in
// the same stage registers. A single advance enable moves the whole pipe, so
// a stalled output freezes every stage (no bubble collapsing).
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = ceil_div(WIDTH, CHUNK);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;

    // Per-stage next-state (_d) and registered (_q) values.
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_d   [STAGES];
    logic             c_q   [STAGES];
    logic             ovf_d [STAGES];
    logic             ovf_q [STAGES];
    logic             v_d   [STAGES];
    logic             v_q   [STAGES];

    // Subtraction is A + ~B + 1: invert B once at the input, force carry-in.
    always_comb begin
        b_eff   = (sub == MODE_SUB) ? ~b : b;
        c_first = (sub == MODE_SUB) ? 1'b1 : cin;
    end

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv       = out_ready | ~v_q[STAGES-1];
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int N  = (k == STAGES - 1) ? (WIDTH - LO) : CHUNK;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [N-1:0]     sl_s;
        logic             sl_co;
        logic             sl_cm;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c_first;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
        end

        adder_slice #(
            .N (N)
        ) u_slice (
            .a  (a_in[LO +: N]),
            .b  (b_in[LO +: N]),
            .ci (c_in),
            .s  (sl_s),
            .co (sl_co),
            .cm (sl_cm)
        );

        // Resolve this slice; everything else passes through unchanged.
        // Overflow is only meaningful at the last stage, where the slice MSB
        // is the word MSB.
        always_comb begin
            a_d[k]           = a_in;
            b_d[k]           = b_in;
            s_d[k]           = s_in;
            s_d[k][LO +: N]  = sl_s;
            c_d[k]           = sl_co;
            ovf_d[k]         = sl_cm ^ sl_co;
            v_d[k]           = v_in;
        end
    end

    // Pipeline registers: only valid bits are reset; data loads on advance.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (reset) begin
                v_q[k] <= 1'b0;
            end else if (adv) begin
                v_q[k] <= v_d[k];
            end
            if (adv) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor for the arithmetic datapath. It splits a WIDTH-bit operation into CHUNK-bit slices and registers the carry between slices, so wide additions close timing at the board clock. It accepts one operation per cycle under a valid/ready handshake and replaces the fixed-width combinational carry adders wherever a registered or wider result is needed.

## Interface
Parameters:
- WIDTH, 14, operand and result width (≥ 2)
- CHUNK, 4, bits resolved per pipeline stage (1 ≤ CHUNK ≤ WIDTH)
- STAGES (localparam), ceil(WIDTH/CHUNK), pipeline depth; last slice holds WIDTH − (STAGES−1)·CHUNK bits

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in, add mode only
- sub  in  1  0: A+B+cin; 1: A−B (cin ignored)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry-out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow

## Operation
- Sub mode: B slice-wise inverted, carry into slice 0 forced to 1.
- Stage k (0..STAGES−1) adds slice k of A and effective B with registered carry from stage k−1; higher slices of A/B and lower result slices travel alongside in skew registers.
- Each stage holds a valid bit; valid bits reset to 0; data registers need no reset.
- Global advance enable: adv = out_ready | ~out_valid. in_ready = adv. When adv=0 every stage holds (no bubbles collapsed; simple, no interior skid).
- Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
- cout = carry out of last slice; ovf = carry into MSB XOR carry out of MSB, computed in last stage.
- reset mid-operation: all valid bits cleared next edge; in-flight operations discarded; no partial result emitted.
- Reset values: out_valid=0, in_ready=1 (since out_valid=0), sum/cout/ovf undefined but stable (bench masks when out_valid=0).

## Timing
- Latency: STAGES cycles from accepted input to out_valid (default 4).
- Throughput: 1 op/cycle with out_ready held high.
- Backpressure: out_valid=1 and out_ready=0 ⇒ sum/cout/ovf/out_valid held unchanged; in_ready=0 same cycle (combinational from out_ready).
- Order preserved; no operation dropped or duplicated under any in_valid/out_ready pattern.
- CHUNK ≥ WIDTH ⇒ STAGES=1, plain registered adder, latency 1.

## Structure
- Shared package arith_pkg: function ceil_div(int,int) for STAGES; mode encoding constants (MODE_ADD=0, MODE_SUB=1).
- One sub-module: adder_slice (parameter N), N-bit ripple of fulladder cells, inputs a, b, ci, outputs s, co and carry into MSB for overflow. pipelined_adder instantiates STAGES of them via generate plus pipeline registers.

## Test plan
- Add wrap: a=14'h3FFF, b=0, cin=1, sub=0 -> after 4 cycles sum=14'h0000, cout=1, ovf=0.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=14'h3FFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
- Signed overflow: a=14'h1FFF, b=1, sub=0 -> sum=14'h2000, ovf=1, cout=0; a=14'h2000, b=1, sub=1 -> sum=14'h1FFF, ovf=1.
- Streaming + backpressure: 20 back-to-back random ops, out_ready toggled randomly -> results match scoreboard in order, outputs stable while stalled, in_ready=0 exactly when out_valid & ~out_ready.
- Reset mid-flight: 3 ops accepted, reset asserted 1 cycle at cycle 2 -> out_valid stays 0 until a new op is accepted, then appears 4 cycles later.
- Parameter sweep: WIDTH∈{8,14,32}, CHUNK∈{1,3,4,WIDTH} with 1000 random ops each -> sum/cout/ovf match reference model; latency equals ceil(WIDTH/CHUNK).
